fp_mac_vec: RTL and testbench

- Multi-lane, pipelined IEEE-754 single-precision dot-product engine; successor to the single-lane MAC in the classifier datapath.
- Each of LANES lanes accumulates bias + sum(A*B) over a programmable vector length.
- Streaming valid/ready input, held valid/ready output, explicit start/clear control.
- Sits between the feature/weight buffers and the activation stage of the FC/conv layers.

---
 rtl/fp_mac_vec_pkg.sv | 85 ++++++++
 rtl/fp_mac_lane.sv | 36 +++
 rtl/fp_mac_vec.sv | 96 +++++++++
 tb/tb_fp_mac_vec.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mac_vec_pkg.sv
// Shared constants, FSM encoding and the combinational single-precision
// adder/multiplier used by every lane of fp_mac_vec.
package fp_mac_vec_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Round-to-nearest-even; subnormal inputs and underflowing results flush to zero,
  // overflow saturates to infinity. Inf/NaN inputs are not special-cased.
  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic        sgn;
    logic [47:0] p;
    logic [24:0] m;
    logic        g;
    logic        stk;
    int          e;
    sgn = x[31] ^ y[31];
    if (x[30:23] == 8'd0 || y[30:23] == 8'd0) return {sgn, 31'b0};
    p = {24'b0, 1'b1, x[22:0]} * {24'b0, 1'b1, y[22:0]};
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) begin
      m = {1'b0, p[47:24]}; g = p[23]; stk = |p[22:0]; e = e + 1;
    end else begin
      m = {1'b0, p[46:23]}; g = p[22]; stk = |p[21:0];
    end
    if (g && (stk || m[0])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e = e + 1; end
    if (e <= 0) return {sgn, 31'b0};
    if (e >= 255) return {sgn, 8'hFF, 23'b0};
    return {sgn, e[7:0], m[22:0]};
  endfunction

  // Mantissas carry 26 extra low bits; bits shifted out of the smaller operand
  // are jammed into bit 0 so rounding stays correct after cancellation.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] big;
    logic [31:0] sml;
    logic [50:0] mb;
    logic [50:0] ms;
    logic [50:0] s;
    logic [50:0] n;
    logic [24:0] m;
    logic [7:0]  d;
    logic        stk;
    int          idx;
    int          e;
    if (x[30:23] == 8'd0 && y[30:23] == 8'd0) return {x[31] & y[31], 31'b0};
    if (x[30:23] == 8'd0) return y;
    if (y[30:23] == 8'd0) return x;
    if (x[30:0] >= y[30:0]) begin big = x; sml = y; end
    else begin big = y; sml = x; end
    d   = big[30:23] - sml[30:23];
    mb  = {1'b0, 1'b1, big[22:0], 26'b0};
    ms  = {1'b0, 1'b1, sml[22:0], 26'b0};
    stk = 1'b0;
    if (d > 8'd49) begin
      stk = 1'b1; ms = '0;
    end else begin
      for (int i = 0; i < 50; i++) if (i < int'(d) && ms[i]) stk = 1'b1;
      ms = ms >> d;
    end
    ms[0] = ms[0] | stk;
    s = (big[31] == sml[31]) ? mb + ms : mb - ms;
    if (s == '0) return 32'h0;
    idx = 0;
    for (int i = 0; i < 51; i++) if (s[i]) idx = i;
    n = s << (50 - idx);
    e = int'(big[30:23]) + idx - 49;
    m = {1'b0, n[50:27]};
    if (n[26] && ((|n[25:0]) || n[27])) m = m + 25'd1;
    if (m[24]) begin m = m >> 1; e = e + 1; end
    if (e <= 0) return {big[31], 31'b0};
    if (e >= 255) return {big[31], 8'hFF, 23'b0};
    return {big[31], e[7:0], m[22:0]};
  endfunction

endpackage

// File: rtl/fp_mac_lane.sv
// One accumulator lane: stage-1 product register, stage-2 accumulator.
module fp_mac_lane
  import fp_mac_vec_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            load_bias,
  input  logic            beat_en,
  input  logic            pvalid,
  input  logic [FP_W-1:0] bias,
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] acc
);

  logic [FP_W-1:0] prod;
  logic [FP_W-1:0] acc_r;
  logic [FP_W-1:0] sum;

  assign sum = fp_add(acc_r, prod);
  // acc is the running total including a product still waiting in stage 1.
  assign acc = pvalid ? sum : acc_r;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prod  <= FP_ZERO;
      acc_r <= FP_ZERO;
    end else begin
      if (beat_en) prod <= fp_mul(a, b);
      if (load_bias)   acc_r <= bias;
      else if (pvalid) acc_r <= sum;
    end
  end

endmodule

// File: rtl/fp_mac_vec.sv
// Multi-lane pipelined single-precision dot-product engine: shared control
// FSM, beat counter and handshakes around LANES fp_mac_lane instances.
module fp_mac_vec
  import fp_mac_vec_pkg::*;
#(
  parameter int LANES = 4,
  parameter int LEN_W = 16,
  parameter int FP_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic [LANES*FP_W-1:0] bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*FP_W-1:0] a,
  input  logic [LANES*FP_W-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*FP_W-1:0] y,
  output logic                  busy,
  output state_e                state_dbg
);

  if (FP_W != fp_mac_vec_pkg::FP_W) begin : g_bad_fp_w
    $error("fp_mac_vec supports only FP_W = 32");
  end

  state_e                 state;
  state_e                 state_nx;
  logic [LEN_W-1:0]       cnt;
  logic                   pvalid;
  logic                   load_bias;
  logic                   beat_en;
  logic [LANES*FP_W-1:0]  acc_all;

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst || clr) state <= S_IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (len == '0) ? S_DONE : S_ACCUM;
      S_ACCUM: if (in_valid && cnt == LEN_W'(1)) state_nx = S_DRAIN;
      S_DRAIN: if (pvalid) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Handshakes: a beat transfers on an edge where in_valid && in_ready; a result
  // transfers where out_valid && out_ready. Neither ready depends on its valid.
  always_comb begin
    in_ready  = (state == S_ACCUM);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
    load_bias = (state == S_IDLE) && start;
    beat_en   = (state == S_ACCUM) && in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt    <= '0;
      pvalid <= 1'b0;
      y      <= '0;
    end else begin
      pvalid <= beat_en;
      if (load_bias)    cnt <= len;
      else if (beat_en) cnt <= cnt - LEN_W'(1);
      if (load_bias && len == '0)       y <= bias;
      else if (state == S_DRAIN && pvalid) y <= acc_all;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_mac_lane u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .load_bias (load_bias),
      .beat_en   (beat_en),
      .pvalid    (pvalid),
      .bias      (bias[i*FP_W +: FP_W]),
      .a         (a[i*FP_W +: FP_W]),
      .b         (b[i*FP_W +: FP_W]),
      .acc       (acc_all[i*FP_W +: FP_W])
    );
  end

endmodule

// File: tb/tb_fp_mac_vec.sv
// Directed + randomized bench for fp_mac_vec; expected results come from
// exact fixed-point sums converted to single precision.
module tb_fp_mac_vec;
  import fp_mac_vec_pkg::*;

  localparam int LANES = 4;
  localparam int LEN_W = 16;
  localparam int W     = LANES * 32;

  logic             clk;
  logic             rst;
  logic             clr;
  logic             start;
  logic [LEN_W-1:0] len;
  logic [W-1:0]     bias;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     y;
  logic             busy;
  state_e           state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  // Operands are a_i/2 and b_i/2, bias is bias_q/4: all sums are exact in float.
  int a_i[16][LANES];
  int b_i[16][LANES];
  int bias_q[LANES];

  fp_mac_vec #(.LANES(LANES), .LEN_W(LEN_W), .FP_W(32)) dut (
    .clk(clk), .rst(rst), .clr(clr), .start(start), .len(len), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference helpers ----------------
  function automatic logic [31:0] int_to_fp(input int v, input int fb);
    logic [31:0] r;
    logic [31:0] sh;
    int mag;
    int p;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
    sh = 32'(mag << (23 - p));
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p - fb);
    r[22:0]  = sh[22:0];
    return r;
  endfunction

  function automatic logic [W-1:0] pack_bias();
    logic [W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*32 +: 32] = int_to_fp(bias_q[l], 2);
    return v;
  endfunction

  function automatic logic [W-1:0] pack_a(input int k);
    logic [W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*32 +: 32] = int_to_fp(a_i[k][l], 1);
    return v;
  endfunction

  function automatic logic [W-1:0] pack_b(input int k);
    logic [W-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*32 +: 32] = int_to_fp(b_i[k][l], 1);
    return v;
  endfunction

  function automatic int rnd_small();
    return int'($urandom_range(16, 0)) - 8;
  endfunction

  task automatic rand_job_data(input int n);
    for (int l = 0; l < LANES; l++) begin
      bias_q[l] = int'($urandom_range(40, 0)) - 20;
      for (int k = 0; k < n; k++) begin
        a_i[k][l] = rnd_small();
        b_i[k][l] = rnd_small();
      end
    end
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_job(input int n, input int gap, input int hold, input bit junk, input bit poke);
    logic [W-1:0] exp_y;
    logic [W-1:0] want;
    int waited;
    for (int l = 0; l < LANES; l++) begin
      int acc_q;
      acc_q = bias_q[l];
      for (int k = 0; k < n; k++) acc_q += a_i[k][l] * b_i[k][l];
      exp_y[l*32 +: 32] = int_to_fp(acc_q, 2);
    end
    exp_q.push_back(exp_y);

    if (junk) begin
      in_valid = 1'b1; a = {4{$urandom}}; b = {4{$urandom}};
      step();
    end
    start = 1'b1; len = LEN_W'(n); bias = pack_bias();
    step();
    start = 1'b0; len = 16'($urandom); bias = {4{$urandom}};
    in_valid = 1'b0;
    check("busy_after_start", W'(busy), W'(1));
    if (n == 0) check("len0_no_in_ready", W'(in_ready), W'(0));

    for (int k = 0; k < n; k++) begin
      if (k > 0) repeat (gap) step();
      in_valid = 1'b1; a = pack_a(k); b = pack_b(k);
      if (poke && k == 1) begin start = 1'b1; len = 16'd7; end
      waited = 0;
      while (!in_ready && waited < 20) begin step(); waited++; end
      check("in_ready_beat", W'(in_ready), W'(1));
      step();
      start = 1'b0;
      in_valid = 1'b0;
    end
    if (junk && n > 0) begin
      in_valid = 1'b1; a = {4{$urandom}}; b = {4{$urandom}};
    end

    waited = 0;
    while (!out_valid && waited < 40) begin step(); waited++; end
    check("out_valid_latency", W'(waited), W'((n == 0) ? 0 : 1));
    want = exp_q.pop_front();
    check("y_result", y, want);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      step();
      check("hold_out_valid", W'(out_valid), W'(1));
      check("hold_y", y, want);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("idle_after_accept", W'(busy), W'(0));
    check("out_valid_drop", W'(out_valid), W'(0));
    check("y_kept", y, want);
  endtask

  task automatic partial_job(input int n, input int beats);
    start = 1'b1; len = LEN_W'(n); bias = pack_bias();
    step();
    start = 1'b0;
    for (int k = 0; k < beats; k++) begin
      in_valid = 1'b1; a = pack_a(k); b = pack_b(k);
      check("partial_in_ready", W'(in_ready), W'(1));
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_in_ready"}, W'(in_ready), W'(0));
    check({tag, "_out_valid"}, W'(out_valid), W'(0));
    check({tag, "_y"}, y, '0);
    check({tag, "_state"}, W'(state_dbg), W'(S_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int waited;
    rst = 1'b1; clr = 1'b0; start = 1'b0; len = '0; bias = '0;
    in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b0;
    repeat (2) step();
    check_cleared("reset");
    rst = 1'b0;
    step();

    // basic dot product
    for (int l = 0; l < LANES; l++) begin
      bias_q[l] = 0;
      for (int k = 0; k < 3; k++) begin a_i[k][l] = rnd_small(); b_i[k][l] = rnd_small(); end
    end
    for (int k = 0; k < 3; k++) begin
      a_i[k][0] = 2 * (k + 1); b_i[k][0] = 2;
      a_i[k][1] = 4;           b_i[k][1] = 1;
    end
    do_job(3, 0, 0, 1'b0, 1'b0);
    check("basic_lane0", W'(y[31:0]), W'(32'h40C00000));
    check("basic_lane1", W'(y[63:32]), W'(32'h40400000));

    // backpressure on both sides
    do_job(3, 2, 5, 1'b1, 1'b0);
    check("bp_lane0", W'(y[31:0]), W'(32'h40C00000));

    // len = 0 returns the bias
    rand_job_data(0);
    bias_q[0] = 20;
    do_job(0, 0, 0, 1'b1, 1'b0);
    check("len0_lane0", W'(y[31:0]), W'(32'h40A00000));

    // bias 1.0 + 2.0*4.0
    for (int l = 0; l < LANES; l++) begin bias_q[l] = 4; a_i[0][l] = 4; b_i[0][l] = 8; end
    do_job(1, 0, 1, 1'b0, 1'b0);
    check("bias_len1_lane0", W'(y[31:0]), W'(32'h41100000));

    // clear mid-job
    rand_job_data(3);
    partial_job(3, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_cleared("clr");
    for (int i = 0; i < 4; i++) begin
      step();
      check("clr_no_out_valid", W'(out_valid), W'(0));
    end
    for (int l = 0; l < LANES; l++) begin bias_q[l] = 0; a_i[0][l] = 4; b_i[0][l] = 4; end
    do_job(1, 0, 0, 1'b0, 1'b0);
    check("after_clr_lane0", W'(y[31:0]), W'(32'h40800000));

    // reset mid-job, then a fresh job
    rand_job_data(4);
    partial_job(4, 2);
    rst = 1'b1;
    step();
    check_cleared("rst_mid");
    rst = 1'b0;
    rand_job_data(3);
    do_job(3, 1, 0, 1'b0, 1'b0);

    // reset while holding a result in DONE
    rand_job_data(2);
    partial_job(2, 2);
    waited = 0;
    while (!out_valid && waited < 20) begin step(); waited++; end
    check("done_reached", W'(out_valid), W'(1));
    rst = 1'b1;
    step();
    check_cleared("rst_done");
    rst = 1'b0;
    rand_job_data(2);
    do_job(2, 0, 2, 1'b0, 1'b0);

    // start pulsed during ACCUM is ignored
    rand_job_data(2);
    do_job(2, 1, 1, 1'b0, 1'b1);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      int n;
      n = int'($urandom_range(8, 1));
      rand_job_data(n);
      do_job(n, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
             1'($urandom_range(1, 0)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
